// File: rtl/draw_rect_layer.sv
// draw_rect_layer
//   Overlays up to N_OBJ solid rectangles of RECT_W x RECT_H pixels on a
//   video timing stream. Object positions, enables and blink requests are
//   sampled once per frame, at the rising edge of vblnk_in. Because drawing
//   only ever uses these captured copies, the picture cannot tear mid-frame.
//   Every output lags its input by exactly two clk cycles.
//
//   Optional feature: define DRAW_RECT_BLINK_EN to enable per-object
//   blinking. When it is enabled, an 8-bit frame counter drives the blink
//   phase. An object whose captured blink bit is set is hidden while
//   frame_cnt[BLINK_BIT] = 1. When the macro is not defined, the blink port
//   is still present but has no effect.
//
// Ports
//   clk, rst                      pixel clock, synchronous active-high reset
//   hcount_in, vcount_in  [10:0]  pixel coordinates
//   hsync_in, vsync_in            sync strobes
//   hblnk_in, vblnk_in            blanking strobes
//   rgb_in                [11:0]  background pixel
//   x_pos, y_pos   [12*N_OBJ-1:0] packed top-left corner per object
//   obj_en, blink    [N_OBJ-1:0]  per-object enable / blink request
//   *_out                         registered outputs, 2-cycle latency
module draw_rect_layer #(
   parameter int unsigned          N_OBJ     = 4,
   parameter int unsigned          RECT_W    = 60,
   parameter int unsigned          RECT_H    = 60,
   parameter logic [12*N_OBJ-1:0]  COLORS    = {N_OBJ{12'h0_1_c}},
   parameter int unsigned          BLINK_BIT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [10:0]          hcount_in,
   input  logic [10:0]          vcount_in,
   input  logic                 hsync_in,
   input  logic                 vsync_in,
   input  logic                 hblnk_in,
   input  logic                 vblnk_in,
   input  logic [11:0]          rgb_in,
   input  logic [12*N_OBJ-1:0]  x_pos,
   input  logic [12*N_OBJ-1:0]  y_pos,
   input  logic [N_OBJ-1:0]     obj_en,
   input  logic [N_OBJ-1:0]     blink,
   output logic [10:0]          hcount_out,
   output logic [10:0]          vcount_out,
   output logic                 hsync_out,
   output logic                 vsync_out,
   output logic                 hblnk_out,
   output logic                 vblnk_out,
   output logic [11:0]          rgb_out
);

   localparam logic [12:0] W13 = 13'(RECT_W);
   localparam logic [12:0] H13 = 13'(RECT_H);

   logic                vblnk_prev;
   logic                frame_start;
   logic [12*N_OBJ-1:0] x_sh;
   logic [12*N_OBJ-1:0] y_sh;
   logic [N_OBJ-1:0]    en_sh;
   logic [N_OBJ-1:0]    hit;

   logic [N_OBJ-1:0]    hit_s1;
   logic [10:0]         hcount_s1;
   logic [10:0]         vcount_s1;
   logic                hsync_s1;
   logic                vsync_s1;
   logic                hblnk_s1;
   logic                vblnk_s1;
   logic [11:0]         rgb_s1;
   logic [11:0]         pix;
   logic                found;

   assign frame_start = vblnk_in & ~vblnk_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         x_sh       <= '0;
         y_sh       <= '0;
         en_sh      <= '0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (frame_start) begin
            x_sh  <= x_pos;
            y_sh  <= y_pos;
            en_sh <= obj_en;
         end
      end
   end

`ifdef DRAW_RECT_BLINK_EN
   logic [N_OBJ-1:0] blink_sh;
   logic [7:0]       frame_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_sh  <= '0;
         frame_cnt <= '0;
      end else if (frame_start) begin
         blink_sh  <= blink;
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^blink;
`endif

   // All bounds are compared in 13 bits so that x+RECT_W never wraps past
   // 2047/4095. As a result, rectangles are clipped at the edge and never
   // reappear at column or row 0.
   always_comb begin
      hit = '0;
      for (int unsigned k = 0; k < N_OBJ; k++) begin
         hit[k] = en_sh[k]
                  && ({2'b00, hcount_in} >= {1'b0, x_sh[12*k +: 12]})
                  && ({2'b00, hcount_in} <  ({1'b0, x_sh[12*k +: 12]} + W13))
                  && ({2'b00, vcount_in} >= {1'b0, y_sh[12*k +: 12]})
                  && ({2'b00, vcount_in} <  ({1'b0, y_sh[12*k +: 12]} + H13));
`ifdef DRAW_RECT_BLINK_EN
         if (blink_sh[k] && frame_cnt[BLINK_BIT])
            hit[k] = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_s1    <= '0;
         hcount_s1 <= '0;
         vcount_s1 <= '0;
         hsync_s1  <= 1'b0;
         vsync_s1  <= 1'b0;
         hblnk_s1  <= 1'b0;
         vblnk_s1  <= 1'b0;
         rgb_s1    <= '0;
      end else begin
         hit_s1    <= hit;
         hcount_s1 <= hcount_in;
         vcount_s1 <= vcount_in;
         hsync_s1  <= hsync_in;
         vsync_s1  <= vsync_in;
         hblnk_s1  <= hblnk_in;
         vblnk_s1  <= vblnk_in;
         rgb_s1    <= rgb_in;
      end
   end

   // Lowest-index hit wins; blanking forces black regardless of hits.
   always_comb begin
      pix   = rgb_s1;
      found = 1'b0;
      for (int unsigned k = 0; k < N_OBJ; k++) begin
         if (!found && hit_s1[k]) begin
            pix   = COLORS[12*k +: 12];
            found = 1'b1;
         end
      end
      if (hblnk_s1 || vblnk_s1)
         pix = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount_s1;
         vcount_out <= vcount_s1;
         hsync_out  <= hsync_s1;
         vsync_out  <= vsync_s1;
         hblnk_out  <= hblnk_s1;
         vblnk_out  <= vblnk_s1;
         rgb_out    <= pix;
      end
   end

endmodule

// File: tb/tb_draw_rect_layer.sv
module tb_draw_rect_layer;

   localparam int N  = 4;
   localparam int RW = 60;
   localparam int RH = 60;
`ifdef DRAW_RECT_BLINK_EN
   localparam int BB = 0;
`else
   localparam int BB = 5;
`endif

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } pix_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [10:0]     hcount_in, vcount_in;
   logic            hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0]     rgb_in;
   logic [12*N-1:0] x_pos, y_pos;
   logic [N-1:0]    obj_en, blink;
   logic [10:0]     hcount_out, vcount_out;
   logic            hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0]     rgb_out;

   draw_rect_layer #(
      .N_OBJ     (N),
      .RECT_W    (RW),
      .RECT_H    (RH),
      .COLORS    (48'h01c_00f_0f0_f00),
      .BLINK_BIT (BB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .x_pos      (x_pos),
      .y_pos      (y_pos),
      .obj_en     (obj_en),
      .blink      (blink),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   always #5 clk = ~clk;

   // Reference model: per-frame snapshot of the object list
   logic [11:0] col [N] = '{12'hf00, 12'h0f0, 12'h00f, 12'h01c};
   int   m_x [N];
   int   m_y [N];
   bit   m_en [N];
   bit   m_bl [N];
   int   m_fcnt;
   bit   m_prev_vb;
   pix_t prev_exp;

   int n_assert = 0;
   int n_fail   = 0;

   function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] bg);
      for (int k = 0; k < N; k++) begin
         bit hidden = 1'b0;
`ifdef DRAW_RECT_BLINK_EN
         hidden = m_bl[k] && (((m_fcnt >> BB) & 1) == 1);
`endif
         if (m_en[k] && !hidden && h >= m_x[k] && h < m_x[k] + RW && v >= m_y[k] && v < m_y[k] + RH)
            return col[k];
      end
      return bg;
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_obj(input int k, input int x, input int y, input bit en, input bit bl);
      x_pos[12*k +: 12] = 12'(x);
      y_pos[12*k +: 12] = 12'(y);
      obj_en[k] = en;
      blink[k]  = bl;
   endtask

   task automatic step(input int h, input int v, input bit hb, input bit vb, input logic [11:0] bg);
      pix_t e;
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      rgb_in    = bg;
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      e.h   = hcount_in;
      e.v   = vcount_in;
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      e.hb  = hb;
      e.vb  = vb;
      e.rgb = (hb || vb) ? 12'h000 : model_rgb(h, v, bg);
      if (vb && !m_prev_vb) begin
         for (int k = 0; k < N; k++) begin
            m_x[k]  = int'(x_pos[12*k +: 12]);
            m_y[k]  = int'(y_pos[12*k +: 12]);
            m_en[k] = obj_en[k];
            m_bl[k] = blink[k];
         end
         m_fcnt = (m_fcnt + 1) % 256;
      end
      m_prev_vb = vb;
      @(posedge clk);
      #1;
      chk("timing", 48'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
          48'({prev_exp.h, prev_exp.v, prev_exp.hs, prev_exp.vs, prev_exp.hb, prev_exp.vb}));
      chk("rgb", 48'(rgb_out), 48'(prev_exp.rgb));
      prev_exp = e;
   endtask

   task automatic do_reset(input bit vb);
      rst      = 1'b1;
      vblnk_in = vb;
      hblnk_in = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_rgb", 48'(rgb_out), 48'h0);
      chk("reset_timing", 48'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 48'h0);
      for (int k = 0; k < N; k++) begin
         m_x[k] = 0; m_y[k] = 0; m_en[k] = 1'b0; m_bl[k] = 1'b0;
      end
      m_fcnt    = 0;
      m_prev_vb = 1'b0;
      prev_exp  = '0;
   endtask

   // Drive one visible pixel, then one blank cycle; the pixel reaches rgb_out 2 edges later
   task automatic px(input int h, input int v, input logic [11:0] bg, input logic [11:0] want);
      step(h, v, 1'b0, 1'b0, bg);
      step(0, 0, 1'b1, 1'b0, 12'h000);
      chk($sformatf("px(%0d,%0d)", h, v), 48'(rgb_out), 48'(want));
   endtask

   task automatic new_frame();
      step(0, 767, 1'b0, 1'b0, 12'h000);
      step(0, 768, 1'b1, 1'b1, 12'h000);
      step(0, 769, 1'b1, 1'b1, 12'h000);
   endtask

   initial begin
      int k, h, v, r;
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
      hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
      x_pos = '0; y_pos = '0; obj_en = '0; blink = '0;
      prev_exp = '0;

      do_reset(1'b0);

      // Nothing is drawn before the first frame start
      set_obj(0, 100, 50, 1'b1, 1'b0);
      px(100, 50, 12'h5a5, 12'h5a5);
      new_frame();
      px(100, 50, 12'h5a5, 12'hf00);
      px(160, 50, 12'h5a5, 12'h5a5);
      px(99,  50, 12'h5a5, 12'h5a5);
      px(159, 109, 12'h123, 12'hf00);
      px(159, 110, 12'h123, 12'h123);

      // Overlap: lowest index wins
      set_obj(0, 100, 100, 1'b1, 1'b0);
      set_obj(1, 130, 130, 1'b1, 1'b0);
      new_frame();
      px(140, 140, 12'h777, 12'hf00);
      px(189, 189, 12'h777, 12'h0f0);
      px(120, 120, 12'h777, 12'hf00);

      // Mid-frame position change takes effect only at the next frame start
      set_obj(1, 0, 0, 1'b0, 1'b0);
      set_obj(0, 100, 180, 1'b1, 1'b0);
      new_frame();
      px(100, 200, 12'h0aa, 12'hf00);
      set_obj(0, 300, 180, 1'b1, 1'b0);
      px(100, 200, 12'h0aa, 12'hf00);
      px(300, 200, 12'h0aa, 12'h0aa);
      new_frame();
      px(300, 200, 12'h0aa, 12'hf00);
      px(100, 200, 12'h0aa, 12'h0aa);

      // Clipping at the visible edge and forced black during blanking
      set_obj(0, 0, 0, 1'b0, 1'b0);
      set_obj(2, 1000, 700, 1'b1, 1'b0);
      new_frame();
      px(1023, 700, 12'h321, 12'h00f);
      px(1023, 759, 12'h321, 12'h00f);
      px(1023, 760, 12'h321, 12'h321);
      for (int i = 0; i < 60; i++) px(i, 0, 12'h321, 12'h321);
      step(1010, 710, 1'b1, 1'b0, 12'hfff);
      step(0, 0, 1'b1, 1'b0, 12'h000);
      chk("hblnk_black", 48'(rgb_out), 48'h0);

      // Reset mid-frame clears the outputs and the captured objects
      set_obj(2, 0, 0, 1'b0, 1'b0);
      set_obj(0, 200, 200, 1'b1, 1'b0);
      new_frame();
      px(210, 210, 12'h444, 12'hf00);
      do_reset(1'b0);
      step(210, 210, 1'b0, 1'b0, 12'h444);
      chk("post_reset_rgb", 48'(rgb_out), 48'h0);
      px(210, 210, 12'h444, 12'h444);
      // Reset takes priority over a simultaneous frame start
      step(0, 767, 1'b0, 1'b0, 12'h000);
      do_reset(1'b1);
      px(210, 210, 12'h444, 12'h444);
      new_frame();
      px(210, 210, 12'h444, 12'hf00);

`ifdef DRAW_RECT_BLINK_EN
      // BLINK_BIT=0: hidden on odd frame counts
      set_obj(0, 200, 200, 1'b1, 1'b1);
      for (int f = 0; f < 4; f++) begin
         new_frame();
         px(210, 210, 12'h444, (m_fcnt % 2 == 0) ? 12'hf00 : 12'h444);
      end
      set_obj(0, 200, 200, 1'b1, 1'b0);
`endif

      // Randomized traffic checked cycle by cycle against the model
      for (int j = 0; j < N; j++)
         set_obj(j, int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)), 1'($urandom), 1'($urandom));
      new_frame();
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom % 1000);
         if (r < 4) begin
            new_frame();
         end else if (r < 12) begin
            set_obj(int'($urandom % N), int'($urandom_range(0, 1100)), int'($urandom_range(0, 800)),
                    1'($urandom), 1'($urandom));
         end else begin
            k = int'($urandom % N);
            h = int'(x_pos[12*k +: 12]) + int'($urandom_range(0, 70)) - 5;
            v = int'(y_pos[12*k +: 12]) + int'($urandom_range(0, 70)) - 5;
            if (h < 0) h = 0;
            if (h > 2047) h = 2047;
            if (v < 0) v = 0;
            if (v > 2047) v = 2047;
            step(h, v, ($urandom % 10) == 0, ($urandom % 25) == 0, 12'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/draw_rect_layer.md
DRAW_RECT_LAYER -- requirements
Module: draw_rect_layer

Interface
REQ-001 Parameter N_OBJ, default 4, number of rectangles (1..8).
REQ-002 Parameter RECT_W, default 60, rectangle width in pixels (1..1023).
REQ-003 Parameter RECT_H, default 60, rectangle height in pixels (1..1023).
REQ-004 Parameter COLORS, default {N_OBJ{12'h0_1_c}}, packed 12-bit RGB per object; object k at bits [12k+11:12k].
REQ-005 Parameter BLINK_BIT, default 5, frame-counter bit selecting blink phase (0..7).
REQ-006 The block SHALL have a single clock and a synchronous, active-high reset; ports clk, rst.
REQ-007 clk  in  1  pixel clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 hcount_in, vcount_in  in  11 each  pixel coordinates from timing chain.
REQ-010 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes.
REQ-011 rgb_in  in  12  background pixel.
REQ-012 x_pos, y_pos  in  12*N_OBJ each  packed top-left corner per object.
REQ-013 obj_en  in  N_OBJ  per-object visibility enable.
REQ-014 blink  in  N_OBJ  per-object blink request.
REQ-015 hcount_out, vcount_out  out  11 each; hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each; rgb_out  out  12; all registered.

Function
REQ-016 Frame start SHALL be the cycle where vblnk_in=1 and its registered previous value=0.
REQ-017 At frame start, x_pos, y_pos, obj_en, blink SHALL be captured into shadow registers; drawing uses only shadow values (no mid-frame tearing).
REQ-018 An 8-bit frame counter SHALL increment at each frame start, wrapping 255->0.
REQ-019 Object k hit: hcount >= xk, hcount < xk+RECT_W, vcount >= yk, vcount < yk+RECT_H, shadow enable k=1; compares in 13 bits, zero-extended, no wrap.
REQ-020 Objects extending past the visible area SHALL be clipped; no wrap to column/row 0.
REQ-021 Stage 1 SHALL register the N_OBJ hit vector plus all timing inputs and rgb_in; stage 2 SHALL register the outputs.
REQ-022 Latency SHALL be exactly 2 clk for every output; all timing outputs equal the inputs delayed 2 cycles.
REQ-023 Overlap: lowest-index hit object SHALL win; no hit passes rgb_in.
REQ-024 If hblnk or vblnk (stage-1 copy) is 1, rgb_out SHALL be 12'h000 regardless of hits.
REQ-025 Changes to x_pos/y_pos/obj_en/blink outside frame start SHALL have no effect until the next frame start.

Reset
REQ-026 On rst=1 at a clk edge, all outputs, pipeline registers, shadow registers, frame counter and vblnk history SHALL be 0.
REQ-027 After reset no object SHALL be drawn until the first frame start (shadow enables 0).
REQ-028 rst SHALL win over a simultaneous frame start; reset mid-frame blanks output to 0 for 2 cycles after deassertion.

Configuration
REQ-029 Macro DRAW_RECT_BLINK_EN defined: object k with shadow blink=1 SHALL be treated as not hit while frame_cnt[BLINK_BIT]=1.
REQ-030 DRAW_RECT_BLINK_EN undefined: blink port SHALL remain present but be ignored; frame counter may be omitted; behaviour otherwise identical.

Verification
REQ-031 Defaults, obj0 at (100,50) en=1 captured at frame start; pixel (100,50) -> rgb_out=12'h01c 2 cycles later; (160,50) and (99,50) -> rgb_in.
REQ-032 Obj0 (100,100) color 12'hf00, obj1 (130,130) color 12'h0f0, both en; pixel (140,140) -> 12'hf00.
REQ-033 Change x_pos0 from 100 to 300 mid-frame at vcount=200 -> rendering at x=100 until next frame start, then x=300.
REQ-034 Obj at (1000,700) in 1024x768 timing -> drawn to visible edge, pixels (0..59,0) show rgb_in; hblnk_in=1 -> rgb_out=12'h000.
REQ-035 DRAW_RECT_BLINK_EN, BLINK_BIT=0, blink0=1 -> obj0 visible on even frames, hidden on odd frames.
REQ-036 Assert rst for 1 cycle mid-frame -> all outputs 0 next cycle; nothing drawn until following frame start.
